// File: rtl/branch_predict_ctrl_pkg.sv
// Shared definitions for the fetch-side branch predictor.
//   - 2-bit saturating counter encodings and reset value
//   - recovery FSM state encoding
//   - ctr_next(): saturating counter update toward the resolved outcome
package branch_predict_ctrl_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;
    localparam logic [1:0] CTR_RST = CTR_WNT;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_bht_table.sv
// bht_table: 2^IDX_BITS x 2-bit saturating counter array.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (all entries -> WNT)
//   rd_idx/rd_ctr combinational read port (returns the pre-update value on
//                 a same-cycle read/write collision; no bypass)
//   upd_en        update strobe; upd_idx entry moves toward upd_taken
module bht_table
    import branch_predict_ctrl_pkg::*;
#(
    parameter int unsigned IDX_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [1:0]          rd_ctr,
    input  logic                upd_en,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    always_comb begin
        ctr_d = ctr_q;
        if (upd_en) begin
            ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], upd_taken);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RST;
            end
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= ctr_d[i];
            end
        end
    end

    assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: fetch-side branch predictor and mispredict recovery.
//   - pred_taken: combinational lookup of the counter at if_pc[IDX_BITS:1]
//   - resolves conditional branches in EX, trains the counter table and, on
//     a mispredict, issues a one-cycle registered redirect + flush
// Ports:
//   clk, rst                          clock, async active-high reset
//   if_valid, if_is_br, if_pc         fetch lookup; pred_taken out
//   ex_valid, ex_is_br, ex_pc,
//   ex_pred_taken, ex_taken,
//   ex_target, ex_pc_plus2            resolution inputs from EX
//   redirect_valid, redirect_pc,
//   flush                             registered recovery outputs
// Optional build macro BRSTAT_EN adds br_count / mispred_count (16-bit,
// saturating, counting resolve events and mispredicts).
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int unsigned IDX_BITS = 3,
    parameter int unsigned PC_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic            if_is_br,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic            ex_is_br,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic [PC_W-1:0] ex_pc_plus2,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush
`ifdef BRSTAT_EN
    ,
    output logic [15:0]     br_count,
    output logic [15:0]     mispred_count
`endif
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [1:0]      rd_ctr;
    logic            resolve;
    logic            mispredict;

    // EX contents are wrong-path while FLUSH is showing, so resolution is
    // gated on IDLE: no training and no second redirect.
    assign resolve    = ex_valid & ex_is_br & (state_q == ST_IDLE);
    assign mispredict = resolve & (ex_taken != ex_pred_taken);

    bht_table #(
        .IDX_BITS (IDX_BITS)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (if_pc[IDX_BITS:1]),
        .rd_ctr    (rd_ctr),
        .upd_en    (resolve),
        .upd_idx   (ex_pc[IDX_BITS:1]),
        .upd_taken (ex_taken)
    );

    assign pred_taken = if_valid & if_is_br & rd_ctr[1];

    always_comb begin
        state_d        = state_q;
        redirect_pc_d  = redirect_pc_q;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mispredict) begin
                    redirect_pc_d = ex_taken ? ex_target : ex_pc_plus2;
                    state_d       = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign redirect_pc = redirect_pc_q;

`ifdef BRSTAT_EN
    logic [15:0] br_count_q, br_count_d;
    logic [15:0] mispred_count_q, mispred_count_d;

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (resolve && (br_count_q != '1)) begin
            br_count_d = br_count_q + 16'd1;
        end
        if (mispredict && (mispred_count_q != '1)) begin
            mispred_count_d = mispred_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;
`endif

    // PC bits outside the table index are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_BITS+1], if_pc[0],
                              ex_pc[PC_W-1:IDX_BITS+1], ex_pc[0]};

endmodule

// File: tb/tb_branch_predict_ctrl.sv
module tb_branch_predict_ctrl;

    logic        clk;
    logic        rst;
    logic        if_valid, if_is_br;
    logic [15:0] if_pc;
    logic        pred_taken;
    logic        ex_valid, ex_is_br, ex_pred_taken, ex_taken;
    logic [15:0] ex_pc, ex_target, ex_pc_plus2;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        flush;
`ifdef BRSTAT_EN
    logic [15:0] br_count, mispred_count;
`endif

    branch_predict_ctrl #(
        .IDX_BITS (3),
        .PC_W     (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_is_br       (if_is_br),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pc_plus2    (ex_pc_plus2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
`ifdef BRSTAT_EN
        ,
        .br_count       (br_count),
        .mispred_count  (mispred_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row per cycle: stimulus, expected same-cycle prediction, and the
    // expected registered redirect state after the following rising edge.
    typedef struct {
        logic        ifv, ifb;
        logic [15:0] ifpc;
        logic        exv, exb;
        logic [15:0] expc;
        logic        expred, extaken;
        logic [15:0] extgt, explus2;
        logic        exp_pred;
        logic        exp_rv;
        logic [15:0] exp_rpc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        rv;
        logic [15:0] rpc;
    } sb_t;

    localparam int NV = 21;
    vec_t vecs [NV];
    sb_t  sbq [$];

    int n_vec  = 0;
    int n_fail = 0;

    function automatic vec_t mk(input logic ifv, ifb, input logic [15:0] ifpc,
                                input logic exv, exb, input logic [15:0] expc,
                                input logic expred, extaken,
                                input logic [15:0] extgt, explus2,
                                input logic exp_pred, exp_rv,
                                input logic [15:0] exp_rpc);
        vec_t v;
        v.ifv = ifv; v.ifb = ifb; v.ifpc = ifpc;
        v.exv = exv; v.exb = exb; v.expc = expc;
        v.expred = expred; v.extaken = extaken;
        v.extgt = extgt; v.explus2 = explus2;
        v.exp_pred = exp_pred; v.exp_rv = exp_rv; v.exp_rpc = exp_rpc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if_valid      = v.ifv;
        if_is_br      = v.ifb;
        if_pc         = v.ifpc;
        ex_valid      = v.exv;
        ex_is_br      = v.exb;
        ex_pc         = v.expc;
        ex_pred_taken = v.expred;
        ex_taken      = v.extaken;
        ex_target     = v.extgt;
        ex_pc_plus2   = v.explus2;
    endtask

    task automatic idle_inputs();
        drive(mk(0,0,16'h0, 0,0,16'h0,0,0,16'h0,16'h0, 0,0,16'h0));
    endtask

    initial begin
        sb_t e;
        // pc -> index = pc[3:1]; every counter starts at 01
        vecs[0]  = mk(1,1,16'h0010, 0,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,16'h0000);
        vecs[1]  = mk(1,1,16'h0010, 1,1,16'h0010,0,1,16'h0040,16'h0012, 0,1,16'h0040);
        vecs[2]  = mk(1,1,16'h0010, 1,1,16'h0008,0,1,16'h0100,16'h000A, 1,0,16'h0040);
        vecs[3]  = mk(1,1,16'h0008, 0,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,16'h0040);
        vecs[4]  = mk(1,0,16'h0010, 1,0,16'h0008,0,1,16'h0100,16'h000A, 0,0,16'h0040);
        vecs[5]  = mk(1,1,16'h0008, 0,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,16'h0040);
        vecs[6]  = mk(1,1,16'h0004, 1,1,16'h0004,1,1,16'h0020,16'h0006, 0,0,16'h0040);
        vecs[7]  = mk(1,1,16'h0004, 1,1,16'h0004,1,1,16'h0020,16'h0006, 1,0,16'h0040);
        vecs[8]  = mk(1,1,16'h0004, 1,1,16'h0004,1,1,16'h0020,16'h0006, 1,0,16'h0040);
        vecs[9]  = mk(1,1,16'h0004, 1,1,16'h0004,1,1,16'h0020,16'h0006, 1,0,16'h0040);
        vecs[10] = mk(1,1,16'h0004, 1,1,16'h0004,1,0,16'h0020,16'h0006, 1,1,16'h0006);
        vecs[11] = mk(1,1,16'h0004, 0,0,16'h0000,0,0,16'h0000,16'h0000, 1,0,16'h0006);
        vecs[12] = mk(1,1,16'h0014, 1,1,16'h0004,0,0,16'h0020,16'h0006, 1,0,16'h0006);
        vecs[13] = mk(1,1,16'h0014, 0,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,16'h0006);
        vecs[14] = mk(1,1,16'h0010, 1,1,16'h0010,1,0,16'h0040,16'h0012, 1,1,16'h0012);
        vecs[15] = mk(1,1,16'h0010, 1,1,16'h000C,0,1,16'h0080,16'h000E, 0,0,16'h0012);
        vecs[16] = mk(1,1,16'h000C, 1,1,16'h000C,0,1,16'h0080,16'h000E, 0,1,16'h0080);
        vecs[17] = mk(1,1,16'h000C, 0,0,16'h0000,0,0,16'h0000,16'h0000, 1,0,16'h0080);
        vecs[18] = mk(1,1,16'h0008, 1,1,16'h000C,1,1,16'h0080,16'h000E, 0,0,16'h0080);
        vecs[19] = mk(0,1,16'h000C, 0,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,16'h0080);
        vecs[20] = mk(1,1,16'h000C, 0,0,16'h0000,0,0,16'h0000,16'h0000, 1,0,16'h0080);

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_redirect_valid", redirect_valid, 1'b0);
        check("reset_flush", flush, 1'b0);
        check("reset_redirect_pc", redirect_pc, 16'h0000);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            e.idx = i; e.rv = vecs[i].exp_rv; e.rpc = vecs[i].exp_rpc;
            sbq.push_back(e);
            @(negedge clk);
            check($sformatf("v%0d_pred_taken", i), pred_taken, vecs[i].exp_pred);
            @(posedge clk);
            #1;
            if (sbq.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL v%0d_scoreboard: got empty queue expected entry", i);
            end else begin
                e = sbq.pop_front();
                check($sformatf("v%0d_redirect_valid", e.idx), redirect_valid, e.rv);
                check($sformatf("v%0d_flush", e.idx), flush, e.rv);
                check($sformatf("v%0d_redirect_pc", e.idx), redirect_pc, e.rpc);
            end
        end
`ifdef BRSTAT_EN
        check("stat_br_count_table", br_count, 16'd10);
        check("stat_mispred_count_table", mispred_count, 16'd4);
`endif

        // Reset while FLUSH is showing: outputs drop without a clock edge.
        drive(mk(0,0,16'h0, 1,1,16'h0010,0,1,16'h0040,16'h0012, 0,0,16'h0));
        @(posedge clk);
        #1;
        idle_inputs();
        check("rstflush_pre_valid", redirect_valid, 1'b1);
        check("rstflush_pre_pc", redirect_pc, 16'h0040);
        #2 rst = 1'b1;
        #1;
        check("rstflush_valid_async", redirect_valid, 1'b0);
        check("rstflush_flush_async", flush, 1'b0);
        check("rstflush_pc_async", redirect_pc, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if_valid = 1'b1; if_is_br = 1'b1; if_pc = 16'(k * 2);
            #1;
            check($sformatf("rst_idx%0d_pred", k), pred_taken, 1'b0);
        end
        @(posedge clk);
        check("rst_post_valid", redirect_valid, 1'b0);

        // Taken resolve on index 0: 01 -> 10 proves the reset value was WNT.
        #1;
        drive(mk(1,1,16'h0010, 1,1,16'h0010,1,1,16'h0040,16'h0012, 0,0,16'h0));
        @(negedge clk);
        check("post_rst_pred_old", pred_taken, 1'b0);
        @(posedge clk);
        #1;
        drive(mk(1,1,16'h0010, 1,1,16'h0002,0,0,16'h0030,16'h0004, 0,0,16'h0));
        @(negedge clk);
        check("post_rst_pred_new", pred_taken, 1'b1);
        @(posedge clk);
        #1;
        check("post_rst_no_redirect", redirect_valid, 1'b0);
        drive(mk(0,0,16'h0, 1,1,16'h0006,0,1,16'h0060,16'h0008, 0,0,16'h0));
        @(posedge clk);
        #1;
        idle_inputs();
        check("post_rst_redirect_valid", redirect_valid, 1'b1);
        check("post_rst_flush", flush, 1'b1);
        check("post_rst_redirect_pc", redirect_pc, 16'h0060);
        @(posedge clk);
        #1;
        check("post_rst_redirect_one_cycle", redirect_valid, 1'b0);
`ifdef BRSTAT_EN
        check("stat_br_count", br_count, 16'd3);
        check("stat_mispred_count", mispred_count, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Fetch-side branch predictor and misprediction recovery sequencer for the 5-stage pipeline.
- Holds a table of 2-bit saturating counters indexed by PC and supplies a taken/not-taken prediction to fetch.
- Compares each resolved conditional branch in EX (taken flag from the branch condition unit) against its carried prediction.
- On a mismatch, sequences a registered redirect plus a pipeline flush.

Parameters:
IDX_BITS, 3, log2 of table entries (8 entries); index = pc[IDX_BITS:1].
PC_W, 16, PC/address width.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
if_valid  in  1  fetch stage presenting a valid instruction
if_is_br  in  1  predecoded conditional branch at fetch
if_pc  in  PC_W  fetch PC
pred_taken  out  1  combinational prediction for if_pc; 0 when !(if_valid & if_is_br)
ex_valid  in  1  one-cycle pulse per instruction resolving in EX
ex_is_br  in  1  EX instruction is a conditional branch
ex_pc  in  PC_W  PC of EX instruction
ex_pred_taken  in  1  prediction carried down the pipe with the instruction
ex_taken  in  1  actual outcome from branch condition unit
ex_target  in  PC_W  computed branch target
ex_pc_plus2  in  PC_W  fall-through address
redirect_valid  out  1  fetch must load redirect_pc this cycle
redirect_pc  out  PC_W  corrected fetch address
flush  out  1  squash IF/ID and ID/EX contents this cycle

Behaviour:
- Reset:
  - All counters are set to 01 (weakly not-taken).
  - FSM goes to IDLE.
  - redirect_valid=0, flush=0, redirect_pc=0.
  - Reset mid-FLUSH aborts the redirect immediately.
- Counter encoding:
  - 00 SNT, 01 WNT, 10 WT, 11 ST.
  - Predict taken iff bit1=1.
  - Taken increments and saturates at 11; not-taken decrements and saturates at 00.
- Lookup: combinational read of entry if_pc[IDX_BITS:1]. Reads are zero-latency.
- Resolve event: the cycle with ex_valid & ex_is_br & state==IDLE. In that cycle:
  - Update entry ex_pc[IDX_BITS:1] with ex_taken on the clock edge.
  - Mispredict = ex_taken != ex_pred_taken.
- Read/write collision (same index looked up and updated in one cycle): lookup returns the pre-update value. No bypass.
- FSM states:
  - IDLE: on a mispredict, latch redirect_pc = ex_taken ? ex_target : ex_pc_plus2, then go to FLUSH.
  - FLUSH: redirect_valid=1 and flush=1 for exactly one cycle, then back to IDLE.
- Latency: redirect and flush assert on the cycle after detection. Both are registered outputs, with no combinational path from EX inputs.
- While in FLUSH, all ex_* inputs are wrong-path:
  - No table update.
  - No new mispredict detection.
- Back-to-back mispredicts: the first mispredict occupies FLUSH, so the next detection can happen on the following IDLE cycle at the earliest.
- ex_valid with !ex_is_br: no table update, no redirect.
- The counter is updated on a correct prediction too (strengthens toward the outcome).
- PC index ignores pc[0]. Aliasing between PCs that share an index is permitted.

Optional Feature:
Macro BRSTAT_EN adds two outputs:
- br_count[15:0]: counts resolve events.
- mispred_count[15:0]: counts mispredicts.

Both counters saturate at 16'hFFFF, reset to 0, and are not cleared by flush. Without the macro, neither the ports nor the counters exist, and the remaining behaviour is identical.

Decomposition:
Shared package holds:
- Counter encoding constants (SNT/WNT/WT/ST).
- Counter reset value WNT.
- FSM state encoding (IDLE, FLUSH).

Natural sub-module: bht_table, the 2^IDX_BITS x 2-bit counter array. It has:
- One combinational read port.
- One synchronous write/update port with the saturating increment/decrement logic.
- Asynchronous reset to WNT.

Test Plan:
- Reset, then fetch a branch at if_pc=0x0010 -> pred_taken=0; counter at index 0 reads 01.
- Resolve branch pc=0x0010 with ex_pred_taken=0, ex_taken=1, target=0x0040 -> next cycle redirect_valid=1, flush=1, redirect_pc=0x0040, one cycle only; subsequent lookup of 0x0010 -> pred_taken=1.
- Four taken resolves at pc=0x0004 with a correct prediction each time -> counter saturates at 11, no redirect; then one not-taken (pred=1) -> redirect_pc=ex_pc_plus2=0x0006, counter=10, prediction still taken.
- Mispredict at cycle N, plus ex_valid mispredict input at N+1 (FLUSH) -> only one redirect pulse; table entry for the N+1 PC unchanged.
- Same-cycle lookup and update of index 2 (pc 0x0004 and 0x0014) -> pred_taken reflects the old value; the new value is visible next cycle.
- Assert rst while in FLUSH -> redirect_valid/flush drop asynchronously, all counters return to 01; with BRSTAT_EN, drive 3 resolves with 1 mispredict -> br_count=3, mispred_count=1.
